// File: rtl/adsr_poly_pkg.sv
// Shared types, fixed-point constants and arithmetic helpers for the polyphonic ADSR.
// Fixed-point format is signed Q(TOTAL_BITS-FRACTIONAL_BITS).FRACTIONAL_BITS.
package adsr_poly_pkg;

    localparam int TOTAL_BITS      = 32;
    localparam int FRACTIONAL_BITS = 16;
    localparam int AMPLITUDE_BITS  = 16;

    typedef logic [AMPLITUDE_BITS-1:0]      amplitude;
    typedef logic signed [TOTAL_BITS-1:0]   fixed_t;

    localparam fixed_t ONE     = 32'sh0000_FFFF;
    localparam fixed_t UNITY   = 32'sh0001_0000;
    localparam fixed_t LOG2E_F = 32'sd94548;

    // Overshoot ratios 0.3 / 0.01 / 0.01; alpha = -ln((1+ratio)/ratio)
    localparam fixed_t ATTACK_RATIO_F  = 32'sd19661;
    localparam fixed_t ATTACK_ALPHA    = -32'sd96098;
    localparam fixed_t DECAY_RATIO_F   = 32'sd655;
    localparam fixed_t DECAY_ALPHA     = -32'sd302455;
    localparam fixed_t RELEASE_RATIO_F = 32'sd655;
    localparam fixed_t RELEASE_ALPHA   = -32'sd302455;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_ATTACK  = 5'b00010,
        S_DECAY   = 5'b00100,
        S_SUSTAIN = 5'b01000,
        S_RELEASE = 5'b10000
    } eg_state_t;

    typedef enum logic [0:0] {
        SW_IDLE = 1'b0,
        SW_RUN  = 1'b1
    } sweep_state_t;

    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        logic signed [2*TOTAL_BITS-1:0] w_p;
        w_p = (2*TOTAL_BITS)'(a) * (2*TOTAL_BITS)'(b);
        return fixed_t'(w_p >>> FRACTIONAL_BITS);
    endfunction

    // exp(x) for x<=0 as 2^(x*log2e): integer part is a shift, fraction uses 2^-f ~ 1-f/2
    function automatic fixed_t fx_exp(input fixed_t x);
        logic signed [2*TOTAL_BITS-1:0] w_mag;
        logic [2*TOTAL_BITS-1:0]        w_prod;
        logic [TOTAL_BITS-1:0]          w_y;
        logic [TOTAL_BITS-1:0]          w_n;
        fixed_t                         w_mant;
        fixed_t                         w_res;
        w_mag  = -(2*TOTAL_BITS)'(x);
        w_prod = $unsigned(w_mag) * (2*TOTAL_BITS)'($unsigned(LOG2E_F));
        w_y    = TOTAL_BITS'(w_prod >> FRACTIONAL_BITS);
        w_n    = w_y >> FRACTIONAL_BITS;
        w_mant = UNITY - fixed_t'((w_y & 32'h0000_FFFF) >> 1);
        if (x >= 32'sd0) begin
            w_res = UNITY;
        end else if (w_n >= 32'd32) begin
            w_res = 32'sd0;
        end else begin
            w_res = w_mant >>> w_n;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/adsr_poly_if.sv
// Bus between the voice allocator / DCA side and the polyphonic envelope generator.
interface adsr_poly_if
    import adsr_poly_pkg::*;
#(
    parameter int VOICES = 8
) ();

    logic                    tick;
    logic [VOICES-1:0]       gate;
    fixed_t                  attack_time;
    fixed_t                  decay_time;
    fixed_t                  release_time;
    amplitude                sustain;
    amplitude [VOICES-1:0]   out;
    logic [VOICES-1:0]       active;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    modport master (
        output tick, gate, attack_time, decay_time, release_time, sustain,
        input  out, active, busy, done, overrun
    );

    modport slave (
        input  tick, gate, attack_time, decay_time, release_time, sustain,
        output out, active, busy, done, overrun
    );

endinterface

// File: rtl/adsr_poly_chk.sv
// Invariants of the voice registers: level within [0, ONE] and one-hot stage.
module adsr_poly_chk
    import adsr_poly_pkg::*;
#(
    parameter int VOICES = 8
) (
    input logic      clk,
    input logic      reset,
    input fixed_t    i_level [VOICES],
    input eg_state_t i_state [VOICES]
);

    // per-voice range and encoding checks
    always @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < VOICES; v++) begin
                assert (i_level[v] >= 32'sd0 && i_level[v] <= ONE);
                assert ($onehot(i_state[v]));
            end
        end
    end

endmodule

// File: rtl/adsr_poly_eg_step.sv
// Shared exponential step: picks alpha/time/target by stage and returns the next level.
module adsr_poly_eg_step
    import adsr_poly_pkg::*;
(
    input  eg_state_t i_state,
    input  fixed_t    i_level,
    input  fixed_t    i_attack_time,
    input  fixed_t    i_decay_time,
    input  fixed_t    i_release_time,
    input  fixed_t    i_sustain_fixed,
    output fixed_t    o_next
);

    fixed_t w_alpha;
    fixed_t w_time;
    fixed_t w_target;
    fixed_t w_coef;

    // stage-dependent curve parameters
    always_comb begin
        w_alpha  = 32'sd0;
        w_time   = 32'sd0;
        w_target = 32'sd0;
        case (i_state)
            S_ATTACK: begin
                w_alpha  = ATTACK_ALPHA;
                w_time   = i_attack_time;
                w_target = ONE + ATTACK_RATIO_F;
            end
            S_DECAY: begin
                w_alpha  = DECAY_ALPHA;
                w_time   = i_decay_time;
                w_target = i_sustain_fixed - DECAY_RATIO_F;
            end
            S_RELEASE: begin
                w_alpha  = RELEASE_ALPHA;
                w_time   = i_release_time;
                w_target = -RELEASE_RATIO_F;
            end
            default: begin
                w_alpha  = 32'sd0;
                w_time   = 32'sd0;
                w_target = 32'sd0;
            end
        endcase
    end

    assign w_coef = fx_exp(fx_mul(w_alpha, w_time));
    assign o_next = w_target + fx_mul(i_level - w_target, w_coef);

endmodule

// File: rtl/adsr_poly.sv
// Time-multiplexed ADSR: VOICES envelopes in registers, one step datapath, one voice
// per clock after each accepted tick.
module adsr_poly
    import adsr_poly_pkg::*;
#(
    parameter int VOICES         = 8,
    parameter bit HARD_RETRIGGER = 1'b0
) (
    input logic        clk,
    input logic        reset,
    adsr_poly_if.slave bus
);

    localparam int              IDX_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    sweep_state_t      r_sw;
    sweep_state_t      w_sw_next;
    logic [IDX_W-1:0]  r_idx;
    logic              r_done;
    logic              r_overrun;
    logic [VOICES-1:0] r_gate_q;
    fixed_t            r_level [VOICES];
    eg_state_t         r_state [VOICES];

    logic      w_process;
    logic      w_last;
    logic      w_accept;
    logic      w_overrun_hit;
    eg_state_t w_cur_state;
    eg_state_t w_new_state;
    fixed_t    w_cur_level;
    fixed_t    w_new_level;
    fixed_t    w_next;
    fixed_t    w_sus_fixed;
    logic      w_gate;
    logic      w_gate_q;
    logic      w_rise;
    logic      w_fall;

    // sweep state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw <= SW_IDLE;
        end else begin
            r_sw <= w_sw_next;
        end
    end

    // sweep next state
    always_comb begin
        w_sw_next = r_sw;
        case (r_sw)
            SW_IDLE: begin
                if (bus.tick) begin
                    w_sw_next = SW_RUN;
                end else begin
                    w_sw_next = SW_IDLE;
                end
            end
            SW_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_sw_next = SW_IDLE;
                end else begin
                    w_sw_next = SW_RUN;
                end
            end
            default: w_sw_next = SW_IDLE;
        endcase
    end

    // sweep control outputs
    always_comb begin
        w_process     = 1'b0;
        w_accept      = 1'b0;
        w_overrun_hit = 1'b0;
        case (r_sw)
            SW_IDLE: w_accept = bus.tick;
            SW_RUN: begin
                w_process     = 1'b1;
                w_overrun_hit = bus.tick;
            end
            default: w_process = 1'b0;
        endcase
        w_last = w_process && (r_idx == LAST_IDX);
    end

    // voice index counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_accept || w_last) begin
            r_idx <= '0;
        end else if (w_process) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign w_cur_state = r_state[r_idx];
    assign w_cur_level = r_level[r_idx];
    assign w_gate      = bus.gate[r_idx];
    assign w_gate_q    = r_gate_q[r_idx];
    assign w_rise      = w_gate & ~w_gate_q;
    assign w_fall      = ~w_gate & w_gate_q;
    assign w_sus_fixed = fixed_t'(bus.sustain) <<< (FRACTIONAL_BITS - AMPLITUDE_BITS);

    adsr_poly_eg_step u_eg_step (
        .i_state         (w_cur_state),
        .i_level         (w_cur_level),
        .i_attack_time   (bus.attack_time),
        .i_decay_time    (bus.decay_time),
        .i_release_time  (bus.release_time),
        .i_sustain_fixed (w_sus_fixed),
        .o_next          (w_next)
    );

    // gate edges first, otherwise step the current stage and apply its clamp
    always_comb begin
        w_new_state = w_cur_state;
        w_new_level = w_cur_level;
        if (w_rise) begin
            w_new_state = S_ATTACK;
            if (HARD_RETRIGGER) begin
                w_new_level = 32'sd0;
            end else begin
                w_new_level = w_cur_level;
            end
        end else if (w_fall) begin
            if (w_cur_state != S_IDLE) begin
                w_new_state = S_RELEASE;
            end else begin
                w_new_state = w_cur_state;
            end
        end else begin
            case (w_cur_state)
                S_ATTACK: begin
                    if (w_next >= ONE) begin
                        w_new_level = ONE;
                        w_new_state = S_DECAY;
                    end else begin
                        w_new_level = w_next;
                    end
                end
                S_DECAY: begin
                    if (w_next <= w_sus_fixed) begin
                        w_new_level = w_sus_fixed;
                        w_new_state = S_SUSTAIN;
                    end else begin
                        w_new_level = w_next;
                    end
                end
                S_SUSTAIN: w_new_level = w_sus_fixed;
                S_RELEASE: begin
                    if ((w_next <= 32'sd0) ||
                        (w_next[FRACTIONAL_BITS-1 -: AMPLITUDE_BITS] == '0)) begin
                        w_new_level = 32'sd0;
                        w_new_state = S_IDLE;
                    end else begin
                        w_new_level = w_next;
                    end
                end
                S_IDLE: w_new_level = 32'sd0;
                default: begin
                    w_new_level = 32'sd0;
                    w_new_state = S_IDLE;
                end
            endcase
        end
    end

    // voice register write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < VOICES; v++) begin
                r_level[v] <= 32'sd0;
                r_state[v] <= S_IDLE;
            end
            r_gate_q <= '0;
        end else if (w_process) begin
            r_level[r_idx]  <= w_new_level;
            r_state[r_idx]  <= w_new_state;
            r_gate_q[r_idx] <= w_gate;
        end
    end

    // done pulse and sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_overrun_hit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_out
        assign bus.out[v]    = r_level[v][FRACTIONAL_BITS-1 -: AMPLITUDE_BITS];
        assign bus.active[v] = (r_state[v] != S_IDLE);
    end

    assign bus.busy    = (r_sw == SW_RUN);
    assign bus.done    = r_done;
    assign bus.overrun = r_overrun;

    adsr_poly_chk #(.VOICES(VOICES)) u_chk (
        .clk     (clk),
        .reset   (reset),
        .i_level (r_level),
        .i_state (r_state)
    );

endmodule
